// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared constants and trellis predecessor table for the
//               8-state, rate-1/2 Viterbi decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  localparam int NUM_STATES   = 8;
  localparam int STATE_W      = 3;
  localparam int BM_W         = 2;
  localparam int PM_W_DEFAULT = 6;

  // Predecessor table, one STATE_W-bit field per new state (state 0 in the LSBs).
  // Each new state s is reached from old state s/2 (first) or s/2+4 (second).
  localparam logic [NUM_STATES*STATE_W-1:0] PRED_FIRST = {
    3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0
  };
  localparam logic [NUM_STATES*STATE_W-1:0] PRED_SECOND = {
    3'd7, 3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4
  };

  function automatic int pred_first(input int s);
    return int'(PRED_FIRST[s*STATE_W +: STATE_W]);
  endfunction

  function automatic int pred_second(input int s);
    return int'(PRED_SECOND[s*STATE_W +: STATE_W]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acs_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : acs_butterfly
// Description : Two-input add-compare-select. Picks the smaller of the two
//               candidate metrics; a tie keeps the first predecessor.
// Revision    : 1.0 - initial release
// ============================================================================
module acs_butterfly #(
  parameter int PM_W = 6,
  parameter int BM_W = 2
) (
  input  logic [PM_W-1:0] pm_first,
  input  logic [PM_W-1:0] pm_second,
  input  logic [BM_W-1:0] bm_first,
  input  logic [BM_W-1:0] bm_second,
  output logic [PM_W-1:0] sum,
  output logic            decision
);

  logic [PM_W:0] w_cand_a;
  logic [PM_W:0] w_cand_b;
  logic [PM_W:0] w_sel;

  // Candidates carry one extra bit so the comparison never wraps.
  assign w_cand_a = {1'b0, pm_first}  + {{(PM_W+1-BM_W){1'b0}}, bm_first};
  assign w_cand_b = {1'b0, pm_second} + {{(PM_W+1-BM_W){1'b0}}, bm_second};

  // Strict less-than: equal candidates fall back to the first predecessor.
  assign decision = (w_cand_b < w_cand_a);
  assign w_sel    = decision ? w_cand_b : w_cand_a;

  // Clamp as a safety net; unreachable while INIT_PM stays in range.
  assign sum = w_sel[PM_W] ? {PM_W{1'b1}} : w_sel[PM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/add_compare_select.sv
`default_nettype none
// ============================================================================
// Module      : add_compare_select
// Description : Eight-state ACS stage. Keeps the path metrics, emits one
//               survivor decision per state, the best state index and a
//               normalisation strobe for every enabled trellis step.
// Revision    : 1.0 - initial release
// ============================================================================
module add_compare_select
  import viterbi_pkg::*;
#(
  parameter int PM_W    = PM_W_DEFAULT,
  parameter int INIT_PM = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       acs_enable,
  input  logic [BM_W-1:0]            state1_1_error,
  input  logic [BM_W-1:0]            state1_2_error,
  input  logic [BM_W-1:0]            state2_3_error,
  input  logic [BM_W-1:0]            state2_4_error,
  input  logic [BM_W-1:0]            state3_5_error,
  input  logic [BM_W-1:0]            state3_6_error,
  input  logic [BM_W-1:0]            state4_7_error,
  input  logic [BM_W-1:0]            state4_8_error,
  input  logic [BM_W-1:0]            state5_1_error,
  input  logic [BM_W-1:0]            state5_2_error,
  input  logic [BM_W-1:0]            state6_3_error,
  input  logic [BM_W-1:0]            state6_4_error,
  input  logic [BM_W-1:0]            state7_5_error,
  input  logic [BM_W-1:0]            state7_6_error,
  input  logic [BM_W-1:0]            state8_7_error,
  input  logic [BM_W-1:0]            state8_8_error,
  output logic [NUM_STATES*PM_W-1:0] pm_out,
  output logic [NUM_STATES-1:0]      decisions,
  output logic                       dec_valid,
  output logic [STATE_W-1:0]         best_state,
  output logic                       norm_flag
);

  localparam logic [PM_W-1:0] c_init_pm = PM_W'(INIT_PM);

  logic [PM_W-1:0]       r_pm [NUM_STATES];
  logic [NUM_STATES-1:0] r_decisions;
  logic                  r_dec_valid;
  logic [STATE_W-1:0]    r_best_state;
  logic                  r_norm_flag;

  logic [BM_W-1:0]       w_bm_first  [NUM_STATES];
  logic [BM_W-1:0]       w_bm_second [NUM_STATES];
  logic [PM_W-1:0]       w_sum       [NUM_STATES];
  logic [PM_W-1:0]       w_wr        [NUM_STATES];
  logic [NUM_STATES-1:0] w_dec;
  logic [NUM_STATES-1:0] w_msb;
  logic                  w_norm;

  // Branch metric for the first / second incoming branch of each new state.
  assign w_bm_first  = '{state1_1_error, state1_2_error, state2_3_error, state2_4_error,
                         state3_5_error, state3_6_error, state4_7_error, state4_8_error};
  assign w_bm_second = '{state5_1_error, state5_2_error, state6_3_error, state6_4_error,
                         state7_5_error, state7_6_error, state8_7_error, state8_8_error};

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam int c_first  = pred_first(s);
    localparam int c_second = pred_second(s);

    acs_butterfly #(
      .PM_W (PM_W),
      .BM_W (BM_W)
    ) u_acs (
      .pm_first  (r_pm[c_first]),
      .pm_second (r_pm[c_second]),
      .bm_first  (w_bm_first[s]),
      .bm_second (w_bm_second[s]),
      .sum       (w_sum[s]),
      .decision  (w_dec[s])
    );

    assign w_msb[s] = w_sum[s][PM_W-1];
    // When every survivor has the top bit set, dropping it shifts all metrics
    // down by the same amount and keeps relative ordering intact.
    assign w_wr[s]  = w_norm ? {1'b0, w_sum[s][PM_W-2:0]} : w_sum[s];
  end

  assign w_norm = &w_msb;

  // Argmin tree over the written metrics; ties keep the left (lower-index) side.
  logic [PM_W-1:0]    w_l1_pm  [4];
  logic [STATE_W-1:0] w_l1_idx [4];
  logic [PM_W-1:0]    w_l2_pm  [2];
  logic [STATE_W-1:0] w_l2_idx [2];
  logic [STATE_W-1:0] w_best;

  for (genvar i = 0; i < 4; i++) begin : g_min_l1
    logic w_pick_right;
    assign w_pick_right = (w_wr[2*i+1] < w_wr[2*i]);
    assign w_l1_pm[i]   = w_pick_right ? w_wr[2*i+1] : w_wr[2*i];
    assign w_l1_idx[i]  = w_pick_right ? STATE_W'(2*i+1) : STATE_W'(2*i);
  end

  for (genvar i = 0; i < 2; i++) begin : g_min_l2
    logic w_pick_right;
    assign w_pick_right = (w_l1_pm[2*i+1] < w_l1_pm[2*i]);
    assign w_l2_pm[i]   = w_pick_right ? w_l1_pm[2*i+1] : w_l1_pm[2*i];
    assign w_l2_idx[i]  = w_pick_right ? w_l1_idx[2*i+1] : w_l1_idx[2*i];
  end

  assign w_best = (w_l2_pm[1] < w_l2_pm[0]) ? w_l2_idx[1] : w_l2_idx[0];

  // State update: frame start has priority over a trellis step; strobes last one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : c_init_pm;
      end
      r_decisions  <= '0;
      r_dec_valid  <= 1'b0;
      r_best_state <= '0;
      r_norm_flag  <= 1'b0;
    end else if (frame_start) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : c_init_pm;
      end
      r_decisions  <= '0;
      r_dec_valid  <= 1'b0;
      r_best_state <= '0;
      r_norm_flag  <= 1'b0;
    end else if (acs_enable) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= w_wr[s];
      end
      r_decisions  <= w_dec;
      r_dec_valid  <= 1'b1;
      r_best_state <= w_best;
      r_norm_flag  <= w_norm;
    end else begin
      r_dec_valid  <= 1'b0;
      r_norm_flag  <= 1'b0;
    end
  end

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_pack
    assign pm_out[s*PM_W +: PM_W] = r_pm[s];
  end

  assign decisions  = r_decisions;
  assign dec_valid  = r_dec_valid;
  assign best_state = r_best_state;
  assign norm_flag  = r_norm_flag;

endmodule
`default_nettype wire

// File: tb/tb_add_compare_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_compare_select
// Description : Self-checking bench for add_compare_select: table vectors,
//               scoreboard queue and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_add_compare_select;

  localparam int PM_W    = 6;
  localparam int INIT_PM = 16;
  localparam int NS      = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic acs_enable  = 1'b0;
  logic [1:0] bm [16];

  logic [NS*PM_W-1:0] pm_out;
  logic [NS-1:0]      decisions;
  logic               dec_valid;
  logic [2:0]         best_state;
  logic               norm_flag;

  always #5 clk = ~clk;

  add_compare_select #(
    .PM_W    (PM_W),
    .INIT_PM (INIT_PM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .acs_enable     (acs_enable),
    .state1_1_error (bm[0]),
    .state1_2_error (bm[1]),
    .state2_3_error (bm[2]),
    .state2_4_error (bm[3]),
    .state3_5_error (bm[4]),
    .state3_6_error (bm[5]),
    .state4_7_error (bm[6]),
    .state4_8_error (bm[7]),
    .state5_1_error (bm[8]),
    .state5_2_error (bm[9]),
    .state6_3_error (bm[10]),
    .state6_4_error (bm[11]),
    .state7_5_error (bm[12]),
    .state7_6_error (bm[13]),
    .state8_7_error (bm[14]),
    .state8_8_error (bm[15]),
    .pm_out         (pm_out),
    .decisions      (decisions),
    .dec_valid      (dec_valid),
    .best_state     (best_state),
    .norm_flag      (norm_flag)
  );

  typedef struct {
    logic [NS*PM_W-1:0] pm;
    logic [NS-1:0]      dec;
    logic [2:0]         best;
    logic               norm;
  } exp_t;

  typedef struct {
    logic fs;
    logic en;
    logic [1:0] rx;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Codeword per branch, order 1_1,1_2,2_3,2_4,3_5,3_6,4_7,4_8,5_1,...,8_8.
  logic [1:0] cw [16] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00,
                          2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11};

  logic [PM_W-1:0] m_pm [NS];
  logic [NS-1:0]   m_dec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [NS*PM_W-1:0] pk8(input int v0, input int v1, input int v2,
                                             input int v3, input int v4, input int v5,
                                             input int v6, input int v7);
    return {PM_W'(v7), PM_W'(v6), PM_W'(v5), PM_W'(v4),
            PM_W'(v3), PM_W'(v2), PM_W'(v1), PM_W'(v0)};
  endfunction

  function automatic logic [NS*PM_W-1:0] model_pm_packed();
    logic [NS*PM_W-1:0] p;
    for (int s = 0; s < NS; s++) p[s*PM_W +: PM_W] = m_pm[s];
    return p;
  endfunction

  task automatic set_rx(input logic [1:0] rx);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] d;
      d = cw[i] ^ rx;
      bm[i] = 2'(d[0]) + 2'(d[1]);
    end
  endtask

  task automatic model_init();
    m_pm[0] = '0;
    for (int s = 1; s < NS; s++) m_pm[s] = PM_W'(INIT_PM);
    m_dec = '0;
  endtask

  // Reference trellis step straight from the predecessor list.
  task automatic model_step(output exp_t e);
    logic [PM_W:0]   a, b;
    logic [PM_W-1:0] nw [NS];
    logic            all_hi;
    int              bi;
    all_hi = 1'b1;
    for (int s = 0; s < NS; s++) begin
      a = {1'b0, m_pm[s/2]}     + {{(PM_W-1){1'b0}}, bm[s]};
      b = {1'b0, m_pm[s/2 + 4]} + {{(PM_W-1){1'b0}}, bm[8+s]};
      m_dec[s] = (b < a);
      nw[s]    = m_dec[s] ? b[PM_W-1:0] : a[PM_W-1:0];
      all_hi   = all_hi & nw[s][PM_W-1];
    end
    if (all_hi) for (int s = 0; s < NS; s++) nw[s][PM_W-1] = 1'b0;
    bi = 0;
    for (int s = 1; s < NS; s++) if (nw[s] < nw[bi]) bi = s;
    for (int s = 0; s < NS; s++) m_pm[s] = nw[s];
    e.pm   = model_pm_packed();
    e.dec  = m_dec;
    e.best = 3'(bi);
    e.norm = all_hi;
  endtask

  // One clock: inputs are applied now, model updates at the sampling edge.
  task automatic step(input logic fs, input logic en, input logic use_tab, input exp_t te);
    exp_t e;
    frame_start = fs;
    acs_enable  = en;
    @(posedge clk);
    if (fs) model_init();
    else if (en) begin
      model_step(e);
      sb_q.push_back(use_tab ? te : e);
    end
    #1;
    frame_start = 1'b0;
    acs_enable  = 1'b0;
  endtask

  // Scoreboard: every pending step must produce exactly one dec_valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("dec_valid", 64'(dec_valid), 64'(sb_q.size() > 0));
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        if (dec_valid) begin
          check("pm_out", 64'(pm_out), 64'(e.pm));
          check("decisions", 64'(decisions), 64'(e.dec));
          check("best_state", 64'(best_state), 64'(e.best));
          check("norm_flag", 64'(norm_flag), 64'(e.norm));
        end
      end else begin
        check("norm_idle", 64'(norm_flag), 64'd0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_pm"}, 64'(pm_out), 64'(pk8(0, INIT_PM, INIT_PM, INIT_PM, INIT_PM, INIT_PM, INIT_PM, INIT_PM)));
    check({tag, "_dec"}, 64'(decisions), 64'd0);
    check({tag, "_valid"}, 64'(dec_valid), 64'd0);
    check({tag, "_best"}, 64'(best_state), 64'd0);
    check({tag, "_norm"}, 64'(norm_flag), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tab [5];
    exp_t none;
    exp_t hold_e;
    none = '{pm: '0, dec: '0, best: '0, norm: 1'b0};

    // fs, en, received symbol, expected outputs of that step
    tab[0] = '{fs: 1'b1, en: 1'b0, rx: 2'b00, e: none};
    tab[1] = '{fs: 1'b0, en: 1'b1, rx: 2'b00,
               e: '{pm: pk8(0, 2, 17, 17, 17, 17, 16, 16), dec: 8'b0100_0000, best: 3'd0, norm: 1'b0}};
    tab[2] = '{fs: 1'b0, en: 1'b1, rx: 2'b00,
               e: '{pm: pk8(0, 2, 3, 3, 17, 17, 16, 17), dec: 8'b0111_0000, best: 3'd0, norm: 1'b0}};
    tab[3] = '{fs: 1'b0, en: 1'b1, rx: 2'b11,
               e: '{pm: pk8(2, 0, 3, 3, 4, 4, 3, 5), dec: 8'b0000_0000, best: 3'd1, norm: 1'b0}};
    tab[4] = '{fs: 1'b1, en: 1'b1, rx: 2'b01, e: none};

    set_rx(2'b00);
    model_init();
    #12;
    check_reset_values("reset_initial");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, ending with frame_start colliding with acs_enable.
    for (int i = 0; i < 5; i++) begin
      set_rx(tab[i].rx);
      step(tab[i].fs, tab[i].en, 1'b1, tab[i].e);
    end
    check_reset_values("priority");

    // Normalisation: constant metric 2 on every branch.
    step(1'b1, 1'b0, 1'b0, none);
    for (int i = 0; i < 16; i++) bm[i] = 2'd2;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1, 1'b0, none);
      if (k == 3)  check("norm_step3_pm", 64'(pm_out), 64'(pk8(6, 6, 6, 6, 6, 6, 6, 6)));
      if (k == 10) check("tie_dec", 64'(decisions), 64'd0);
      if (k == 15) check("pre_norm_flag", 64'(norm_flag), 64'd0);
      if (k == 16) begin
        check("norm_pm", 64'(pm_out), 64'd0);
        check("norm_flag", 64'(norm_flag), 64'd1);
      end
      if (k == 17) check("post_norm_pm", 64'(pm_out), 64'(pk8(2, 2, 2, 2, 2, 2, 2, 2)));
    end

    // Tie-break: equal metrics, second candidate one lower for state 0.
    bm[0] = 2'd2;
    bm[8] = 2'd1;
    step(1'b0, 1'b1, 1'b0, none);
    check("tie_b_lower", 64'(decisions[0]), 64'd1);
    check("tie_equal", 64'(decisions[1]), 64'd0);

    // Hold: five idle cycles leave everything in place.
    hold_e.pm  = model_pm_packed();
    hold_e.dec = m_dec;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, none);
      check("hold_pm", 64'(pm_out), 64'(hold_e.pm));
      check("hold_dec", 64'(decisions), 64'(hold_e.dec));
    end

    // Randomised stream with gaps, checked through the scoreboard.
    step(1'b1, 1'b0, 1'b0, none);
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 16; i++) bm[i] = 2'($urandom_range(0, 2));
      step(1'b0, ($urandom_range(0, 3) != 0), 1'b0, none);
    end

    // Asynchronous reset mid-stream, with a strobe outstanding.
    set_rx(2'b10);
    step(1'b0, 1'b1, 1'b0, none);
    #2;
    rst = 1'b0;
    sb_q.delete();
    model_init();
    #1;
    check_reset_values("reset_async");
    @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_rx(2'b00);
    step(1'b0, 1'b1, 1'b1,
         '{pm: pk8(0, 2, 17, 17, 17, 17, 16, 16), dec: 8'b0100_0000, best: 3'd0, norm: 1'b0});
    step(1'b0, 1'b0, 1'b0, none);
    step(1'b0, 1'b0, 1'b0, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_compare_select.md
# add_compare_select

Add-compare-select unit for the 8-state, rate-1/2 Viterbi decoder, directly downstream of `branch_metric`. It consumes the 16 registered 2-bit branch metrics and keeps eight path-metric registers. Each enabled symbol it produces one survivor decision bit per state, the index of the best state, and a normalisation flag. Decisions feed the traceback/survivor memory.

## Interface
Parameters:
- `PM_W`, default 6: path-metric width in bits; minimum 6.
- `INIT_PM`, default 16: initial metric for states 1..7 at frame start; must be below 2^(PM_W-1).

Ports:
- `clk` in, 1 bit: clock.
- `rst` in, 1 bit: reset, asynchronous, active-low.
- `frame_start` in, 1 bit: reinitialise the path metrics for a new frame.
- `acs_enable` in, 1 bit: perform one trellis step. Asserted exactly one cycle after the `branch_enable` cycle of `branch_metric`.
- `stateI_J_error` in, 2 bits each, 16 ports: branch metric for trellis branch I→J. The names are identical to the `branch_metric` outputs.
- `pm_out` out, 8*PM_W bits: path metric of state s (0-based, s = I-1) at bits [s*PM_W +: PM_W].
- `decisions` out, 8 bits: bit s is the survivor select for state s.
- `dec_valid` out, 1 bit: one-cycle strobe; `decisions`, `pm_out` and `best_state` are new.
- `best_state` out, 3 bits: index of the minimum path metric.
- `norm_flag` out, 1 bit: one-cycle strobe; a normalisation was applied this step.

## Operation
Predecessor pairs (0-based new state: first predecessor / second predecessor, with the branch metric used for each):
- s0: p0 via `state1_1_error` / p4 via `state5_1_error`
- s1: p0 via `state1_2_error` / p4 via `state5_2_error`
- s2: p1 via `state2_3_error` / p5 via `state6_3_error`
- s3: p1 via `state2_4_error` / p5 via `state6_4_error`
- s4: p2 via `state3_5_error` / p6 via `state7_5_error`
- s5: p2 via `state3_6_error` / p6 via `state7_6_error`
- s6: p3 via `state4_7_error` / p7 via `state8_7_error`
- s7: p3 via `state4_8_error` / p7 via `state8_8_error`

Per step:
- Candidates: a = pm[first] + bm_first and b = pm[second] + bm_second, each computed at PM_W+1 bits.
- Select: decision = 1 only if b < a. A tie selects the first predecessor (decision 0).
- Normalisation: if every one of the 8 selected metrics has bit PM_W-1 set, clear that bit in all 8 before writing and pulse `norm_flag`.
- Overflow: cannot occur under the `INIT_PM` constraint. Saturation logic is not required.
- `best_state`: argmin of the written (post-normalisation) metrics. On a tie, the lowest index wins.

Frame start and reset:
- `frame_start`: pm[0] = 0 and pm[1..7] = `INIT_PM`. `decisions`, `dec_valid` and `norm_flag` are 0; `best_state` = 0.
- `frame_start` together with `acs_enable`: `frame_start` wins and the step is discarded.
- No enable: all registers hold.

## Timing
- Reset values: `pm_out` = {INIT_PM ×7, 0} (s0 = 0), `decisions` = 0, `dec_valid` = 0, `best_state` = 0, `norm_flag` = 0.
- `acs_enable` high in cycle N: `pm_out`, `decisions`, `best_state` and `norm_flag` are updated at the edge ending cycle N. `dec_valid` is high during cycle N+1 only. Latency is 1 cycle.
- Back-to-back `acs_enable`: one step per cycle at full throughput, with `dec_valid` high continuously.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). No pending strobe survives reset.
- `frame_start` takes effect at the next edge. `dec_valid` is 0 in the following cycle.

## Structure
- Shared package `viterbi_pkg` holds:
  - `NUM_STATES` = 8.
  - The predecessor table: first/second predecessor per state.
  - The default `PM_W`.
- Sub-module `acs_butterfly`: two-input add-compare-select with tie-to-first. It takes the two old metrics and two branch metrics and returns the sum and the decision bit. Instantiate it 8 times.
- The normalisation detect and argmin tree live in the top module.

## Test plan
- **Reset:** assert `rst` low mid-stream → all outputs equal their reset values with no clock edge. `dec_valid` = 0.
- **First step, input 00:** `frame_start`, then one `acs_enable` with branch metrics for received 00 (codeword 00→0, 01/10→1, 11→2) → `pm_out` s0..s7 = 0,2,17,17,17,17,16,16; `decisions` = 8'b0100_0000; `best_state` = 0; `dec_valid` pulses once.
- **Normalisation:** `frame_start`, then all 16 metrics = 2 on consecutive enables → all metrics equal 2k from step 3. At step 16 the written metrics are all 0 and `norm_flag` pulses. From step 4 on, `decisions` = 0.
- **Tie-break:** pm equal on both predecessors with equal branch metrics → decision 0. Set b = a-1 → decision 1.
- **Priority:** `frame_start` and `acs_enable` in the same cycle → metrics initialised and `dec_valid` = 0 next cycle.
- **Hold:** `acs_enable` low for 5 cycles → `pm_out` and `decisions` unchanged and no strobes.
